// File: rtl/ee354_project_pkg.sv
// Shared definitions for the snake game controller: FSM state encoding,
// direction codes, start length and the direction-reversal test.
package ee354_project_pkg;

  typedef enum logic [1:0] {
    INI  = 2'd0,
    RUN  = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RIGHT = 2'b11;

  localparam logic [7:0] START_LEN = 8'd3;

  // Opposite directions share bit 1 (same axis) and differ in bit 0.
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/ee354_project_dir_queue.sv
// Two-entry direction queue with a reversal/duplicate filter. The filter
// compares against the newest queued direction, or the applied direction
// when the queue is empty, so a burst of presses can never reverse the snake.
module ee354_project_dir_queue
  import ee354_project_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic [1:0] dir_in,
  input  logic       pop,
  output logic [1:0] cur_dirn
);

  logic [1:0] slot0;
  logic [1:0] slot1;
  logic [1:0] count;
  logic [1:0] ref_dir;
  logic [1:0] wr_idx;
  logic       accept;
  logic       pop_eff;

  // Reference direction, push acceptance and write slot (after any pop).
  always_comb begin
    ref_dir = cur_dirn;
    if (count == 2'd1) ref_dir = slot0;
    else if (count == 2'd2) ref_dir = slot1;
    pop_eff = pop && (count != 2'd0);
    accept  = push && (count != 2'd2) && (dir_in != ref_dir) &&
              !is_opposite(dir_in, ref_dir);
    wr_idx  = count - {1'b0, pop_eff};
  end

  // Queue storage; a push in the same cycle as a pop lands behind the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_dirn <= DOWN;
      slot0    <= '0;
      slot1    <= '0;
      count    <= '0;
    end else if (clear) begin
      cur_dirn <= DOWN;
      count    <= '0;
    end else begin
      if (pop_eff) begin
        cur_dirn <= slot0;
        slot0    <= slot1;
      end
      if (accept) begin
        if (wr_idx == 2'd0) slot0 <= dir_in;
        else                slot1 <= dir_in;
      end
      count <= count - {1'b0, pop_eff} + {1'b0, accept};
    end
  end

endmodule

// File: rtl/ee354_project_game_ctrl.sv
// Snake game controller: INI/RUN/WIN/LOSE FSM, move-tick generator and the
// direction queue. Define GAME_CTRL_SPEEDUP_EN to shorten the move period as
// the snake grows; otherwise the period stays at TICK_BASE.
module ee354_project_game_ctrl
  import ee354_project_pkg::*;
#(
  parameter int unsigned TICK_BASE = 25_000_000,
  parameter int unsigned TICK_STEP = 1_000_000,
  parameter int unsigned TICK_MIN  = 5_000_000,
  parameter logic [7:0]  WIN_LEN   = 8'd20
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Dir_Valid,
  input  logic [1:0] Dir_In,
  input  logic       Collision,
  input  logic [7:0] Length,
  output logic       q_I,
  output logic       q_Run,
  output logic       q_Win,
  output logic       q_Lose,
  output logic       Move_Tick,
  output logic [1:0] Cur_Dirn,
  output logic       Game_Reset
);

  logic [1:0]  rst_sync;
  logic        rst_n;
  state_t      state;
  state_t      state_next;
  logic [31:0] count;
  logic [31:0] period;
  logic        tick;
  logic        stay_run;
  logic        wrap;
  logic        fire;
  logic        run_entry;
  logic        ini_entry;

  // Reset asserts immediately, deasserts after two clean clock edges.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // FSM state register.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) state <= INI;
    else        state <= state_next;
  end

  // Next-state logic; Collision outranks reaching the winning length.
  always_comb begin
    state_next = state;
    case (state)
      INI:       if (Start) state_next = RUN;
      RUN: begin
        if (Collision)              state_next = LOSE;
        else if (Length >= WIN_LEN) state_next = WIN;
      end
      WIN, LOSE: if (Start) state_next = INI;
      default:   state_next = INI;
    endcase
  end

  // Tick only fires when the game stays in RUN, so no tick leaks into WIN/LOSE.
  always_comb begin
    stay_run  = (state == RUN) && (state_next == RUN);
    wrap      = (count == period - 32'd1);
    fire      = stay_run && wrap;
    run_entry = (state == INI) && (state_next == RUN);
    ini_entry = ((state == WIN) || (state == LOSE)) && (state_next == INI);
  end

  // Move counter and registered tick, held clear outside RUN.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (stay_run) begin
      count <= wrap ? '0 : count + 32'd1;
      tick  <= wrap;
    end else begin
      count <= '0;
      tick  <= 1'b0;
    end
  end

`ifdef GAME_CTRL_SPEEDUP_EN
  logic [7:0]  len_eff;
  logic [31:0] steps;
  logic [31:0] decr;
  logic [31:0] next_period;

  // Period for the next move interval from the current snake length.
  always_comb begin
    len_eff     = (Length < START_LEN) ? START_LEN : Length;
    steps       = {24'd0, (len_eff - START_LEN) >> 2};
    decr        = TICK_STEP * steps;
    next_period = (decr >= TICK_BASE - TICK_MIN) ? TICK_MIN : TICK_BASE - decr;
  end

  // Period register, reloaded on RUN entry and at each tick.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)         period <= TICK_BASE;
    else if (run_entry) period <= TICK_BASE;
    else if (fire)      period <= next_period;
  end
`else
  // Fixed move period.
  always_comb period = TICK_BASE;
`endif

  ee354_project_dir_queue u_dir_queue (
    .clk      (Clk),
    .rst_n    (rst_n),
    .clear    (ini_entry),
    .push     (Dir_Valid && ((state == INI) || (state == RUN))),
    .dir_in   (Dir_In),
    .pop      (fire),
    .cur_dirn (Cur_Dirn)
  );

  assign q_I        = (state == INI);
  assign q_Run      = (state == RUN);
  assign q_Win      = (state == WIN);
  assign q_Lose     = (state == LOSE);
  assign Game_Reset = (state == INI);
  assign Move_Tick  = tick;

endmodule

// File: tb/tb_ee354_project_game_ctrl.sv
// Bench for ee354_project_game_ctrl: directed scenarios plus random play,
// all checked against a game-level model (absolute tick times, a direction
// queue). Honours GAME_CTRL_SPEEDUP_EN like the design.
module tb_ee354_project_game_ctrl;

  localparam int TB_BASE = 8;
  localparam int TB_STEP = 2;
  localparam int TB_MIN  = 2;
`ifdef GAME_CTRL_SPEEDUP_EN
  localparam logic [7:0] TB_WIN = 8'd255;
`else
  localparam logic [7:0] TB_WIN = 8'd5;
`endif

  localparam int S_INI  = 0;
  localparam int S_RUN  = 1;
  localparam int S_WIN  = 2;
  localparam int S_LOSE = 3;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic       Dir_Valid;
  logic [1:0] Dir_In;
  logic       Collision;
  logic [7:0] Length;
  logic       q_I, q_Run, q_Win, q_Lose;
  logic       Move_Tick;
  logic [1:0] Cur_Dirn;
  logic       Game_Reset;

  ee354_project_game_ctrl #(
    .TICK_BASE (TB_BASE),
    .TICK_STEP (TB_STEP),
    .TICK_MIN  (TB_MIN),
    .WIN_LEN   (TB_WIN)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Dir_Valid  (Dir_Valid),
    .Dir_In     (Dir_In),
    .Collision  (Collision),
    .Length     (Length),
    .q_I        (q_I),
    .q_Run      (q_Run),
    .q_Win      (q_Win),
    .q_Lose     (q_Lose),
    .Move_Tick  (Move_Tick),
    .Cur_Dirn   (Cur_Dirn),
    .Game_Reset (Game_Reset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int         m_st;
  int         m_cyc;
  int         m_next_tick;
  logic [1:0] m_cur;
  logic       m_tick;
  logic [1:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int new_period(input int len);
`ifdef GAME_CTRL_SPEEDUP_EN
    int l;
    int p;
    l = (len < 3) ? 3 : len;
    p = TB_BASE - TB_STEP * ((l - 3) / 4);
    return (p < TB_MIN) ? TB_MIN : p;
`else
    return TB_BASE + 0 * len;
`endif
  endfunction

  task automatic model_reset();
    m_st        = S_INI;
    m_cyc       = 0;
    m_next_tick = 0;
    m_cur       = 2'b01;
    m_tick      = 1'b0;
    m_q.delete();
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_st == S_INI, m_st == S_RUN, m_st == S_WIN, m_st == S_LOSE,
            m_tick, m_cur, m_st == S_INI};
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge,
  // then compare every output.
  task automatic step();
    logic       s_start, s_dv, s_col, acc, tk;
    logic [1:0] s_din, rf;
    int         s_len;
    s_start = Start;
    s_dv    = Dir_Valid;
    s_din   = Dir_In;
    s_col   = Collision;
    s_len   = int'(Length);
    @(posedge Clk);
    #1;
    tk  = (m_st == S_RUN) && !s_col && (s_len < int'(TB_WIN)) && (m_cyc + 1 == m_next_tick);
    rf  = (m_q.size() == 0) ? m_cur : m_q[$];
    acc = s_dv && (m_st == S_INI || m_st == S_RUN) && (m_q.size() < 2) &&
          (s_din != rf) && !((s_din[1] == rf[1]) && (s_din[0] != rf[0]));
    if (tk && m_q.size() > 0) m_cur = m_q.pop_front();
    if (acc) m_q.push_back(s_din);
    if (tk) m_next_tick = m_cyc + 1 + new_period(s_len);
    case (m_st)
      S_INI: if (s_start) begin
        m_st        = S_RUN;
        m_next_tick = m_cyc + 1 + TB_BASE;
      end
      S_RUN: begin
        if (s_col) m_st = S_LOSE;
        else if (s_len >= int'(TB_WIN)) m_st = S_WIN;
      end
      default: if (s_start) begin
        m_st  = S_INI;
        m_cur = 2'b01;
        m_q.delete();
      end
    endcase
    m_tick = tk;
    m_cyc++;
    check("outputs", {24'd0, q_I, q_Run, q_Win, q_Lose, Move_Tick, Cur_Dirn, Game_Reset},
          {24'd0, exp_vec()});
  endtask

  task automatic idle_inputs();
    Start     = 1'b0;
    Dir_Valid = 1'b0;
    Dir_In    = 2'b00;
    Collision = 1'b0;
    Length    = 8'd3;
  endtask

  task automatic assert_reset();
    idle_inputs();
    Reset_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_state", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
    check("rst_tick", Move_Tick, 1'b0);
    check("rst_dir", Cur_Dirn, 2'b01);
    check("rst_game_reset", Game_Reset, 1'b1);
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    model_reset();
  endtask

  task automatic press(input logic v, input logic [1:0] d);
    Dir_Valid = v;
    Dir_In    = d;
  endtask

  initial begin
    logic [1:0] exp_cur;
    Reset_n = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    assert_reset();
    release_reset();

    // Tick timing and direction filtering
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("run_entry", q_Run, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      check("tick_at", Move_Tick, (k == 9 || k == 17 || k == 25));
      exp_cur = (k < 9) ? 2'b01 : (k < 17) ? 2'b10 : (k < 25) ? 2'b00 : 2'b11;
      check("dir_at", Cur_Dirn, exp_cur);
      case (k)
        2:       press(1'b1, 2'b00);
        3:       press(1'b1, 2'b10);
        4:       press(1'b1, 2'b11);
        10:      press(1'b1, 2'b00);
        11:      press(1'b1, 2'b11);
        12:      press(1'b1, 2'b01);
        default: press(1'b0, 2'b00);
      endcase
      step();
    end
    press(1'b0, 2'b00);
    // now in cycle 26; advance to cycle 32 (wrap cycle before tick 33)
    repeat (6) step();
    Collision = 1'b1;
    Length    = 8'd5;
    step();
    Collision = 1'b0;
    Length    = 8'd3;
    check("lose_state", {q_I, q_Run, q_Win, q_Lose}, 4'b0001);
    check("lose_no_tick", Move_Tick, 1'b0);
    for (int k = 0; k < 10; k++) begin
      Length    = 8'd5;
      Collision = k[0];
      step();
      check("lose_hold_tick", Move_Tick, 1'b0);
    end
    idle_inputs();
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("ini_state", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
    check("ini_game_reset", Game_Reset, 1'b1);
    check("ini_dir", Cur_Dirn, 2'b01);

    // Win path
    Start = 1'b1;
    step();
    Start  = 1'b0;
    Length = TB_WIN;
    step();
    Length = 8'd3;
    check("win_state", {q_I, q_Run, q_Win, q_Lose}, 4'b0010);
    Start = 1'b1;
    step();
    Start = 1'b0;

    // Reset mid-game with two queued directions
    Start = 1'b1;
    step();
    Start = 1'b0;
    press(1'b1, 2'b10);
    step();
    press(1'b1, 2'b00);
    step();
    press(1'b0, 2'b00);
    step();
    step();
    assert_reset();
    check("midrst_state", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
    check("midrst_tick", Move_Tick, 1'b0);
    check("midrst_dir", Cur_Dirn, 2'b01);
    release_reset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (8) step();
    check("post_rst_tick", Move_Tick, 1'b1);
    check("post_rst_fifo_empty", Cur_Dirn, 2'b01);
    Collision = 1'b1;
    step();
    Collision = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;

`ifdef GAME_CTRL_SPEEDUP_EN
    // Speed-up: Length 11 gives period 4, Length 200 hits the floor of 2
    Length = 8'd11;
    Start  = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      check("speed_tick_at", Move_Tick,
            (k == 9 || k == 13 || k == 17 || k == 19 || k == 21 || k == 23 || k == 25));
      if (k == 14) Length = 8'd200;
      step();
    end
    Collision = 1'b1;
    step();
    Collision = 1'b0;
    Start = 1'b1;
    step();
    idle_inputs();
`endif

    // Random play
    for (int i = 0; i < 4000; i++) begin
      Start     = ($urandom_range(0, 15) == 0);
      Dir_Valid = ($urandom_range(0, 2) == 0);
      Dir_In    = 2'($urandom_range(0, 3));
      Collision = ($urandom_range(0, 149) == 0);
      Length    = ($urandom_range(0, 59) == 0) ? TB_WIN : 8'($urandom_range(0, int'(TB_WIN) - 1));
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
